// File: rtl/resp_router_bridge_pkg.sv
// ============================================================================
// Module      : resp_router_bridge_pkg
// Description : Shared bridge package. Provides the outstanding-counter width
//               helper and the one-hot check used on response IDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package resp_router_bridge_pkg;

  // Widest ID the one-hot helper accepts; callers zero-extend into it.
  localparam int ONEHOT_MAX_W = 64;

  // Counter must represent 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
    return ($countones(vec) == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/resp_outstanding_cnt.sv
// ============================================================================
// Module      : resp_outstanding_cnt
// Description : Outstanding-transaction counter for one master, with a
//               registered full flag.
// Ports       : clk, rst_n  - clock, async active-low reset
//               issue       - request granted this cycle
//               ret         - response returned this cycle
//               cnt         - current outstanding count
//               full        - cnt == MAX_OUTSTANDING (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_outstanding_cnt
  import resp_router_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             ret,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_next;

  // Issue and return together cancel out; saturation guards keep the
  // counter in range even if a caller misbehaves.
  always_comb begin
    cnt_next = cnt;
    if (issue && !ret && (cnt != C_MAX)) begin
      cnt_next = cnt + C_ONE;
    end else if (ret && !issue && (cnt != '0)) begin
      cnt_next = cnt - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      full <= (cnt_next == C_MAX);
    end
  end

endmodule

`default_nettype wire

// File: rtl/resp_router_bridge.sv
// ============================================================================
// Module      : resp_router_bridge
// Description : Response-path router for the bridge. Routes each slave
//               response to its master by one-hot ID, tracks outstanding
//               transactions per master and masks requests of full masters.
// Ports       : clk, rst_n           - clock, async active-low reset
//               data_req_i/_o        - raw / masked master requests
//               data_gnt_i           - per-master grants from the tree
//               data_r_*_i           - slave response (valid, ID, data, opc, aux)
//               data_r_valid_o       - per-master response valid (1-cycle latency)
//               data_r_rdata/opc/aux_o - broadcast response payload
//               resp_err_o, err_ID_o - violation pulse and last violating ID
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_router_bridge
  import resp_router_bridge_pkg::*;
#(
  parameter int N_MASTER        = 16,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int DATA_WIDTH      = 32,
  parameter int AUX_WIDTH       = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_MASTER-1:0]   data_req_i,
  output logic [N_MASTER-1:0]   data_req_o,
  input  logic [N_MASTER-1:0]   data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [ID_WIDTH-1:0]   data_r_ID_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
  output logic [N_MASTER-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic [AUX_WIDTH-1:0]  data_r_aux_o,
  output logic                  resp_err_o,
  output logic [ID_WIDTH-1:0]   err_ID_o
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [N_MASTER-1:0] full;
  logic [N_MASTER-1:0] cnt_nz;
  logic [N_MASTER-1:0] issue;
  logic [N_MASTER-1:0] ret;
  logic                id_onehot;
  logic                id_hit;
  logic                resp_ok;
  logic                resp_bad;

  // full is registered, so this mask has no combinational path back
  // through the arbitration tree.
  assign data_req_o = data_req_i & ~full;
  assign issue      = data_req_o & data_gnt_i;

  assign id_onehot = is_onehot(ONEHOT_MAX_W'(data_r_ID_i));
  // With a one-hot ID, a nonzero overlap means the addressed master has
  // something outstanding.
  assign id_hit    = |(data_r_ID_i[N_MASTER-1:0] & cnt_nz);
  assign resp_ok   = data_r_valid_i & id_onehot & id_hit;
  assign resp_bad  = data_r_valid_i & ~(id_onehot & id_hit);
  assign ret       = resp_ok ? data_r_ID_i[N_MASTER-1:0] : '0;

  for (genvar m = 0; m < N_MASTER; m++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    resp_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .issue (issue[m]),
      .ret   (ret[m]),
      .cnt   (cnt),
      .full  (full[m])
    );

    assign cnt_nz[m] = (cnt != '0);
  end

  // Response register stage. Payload is captured on any valid response and
  // held otherwise; only accepted responses raise a per-master valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r_valid_o <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
      data_r_aux_o   <= '0;
      resp_err_o     <= 1'b0;
      err_ID_o       <= '0;
    end else begin
      data_r_valid_o <= ret;
      resp_err_o     <= resp_bad;
      if (data_r_valid_i) begin
        data_r_rdata_o <= data_r_rdata_i;
        data_r_opc_o   <= data_r_opc_i;
        data_r_aux_o   <= data_r_aux_i;
      end
      if (resp_bad) begin
        err_ID_o <= data_r_ID_i;
      end
    end
  end

endmodule

`default_nettype wire
